// File: rtl/usb_in_packetizer.sv
// Frames bytes popped from the byte fifo into USB bulk IN packets (full, short, optional ZLP).
// state     | meaning
// IDLE      | no packet open, waiting for the fifo
// HOLD      | one byte popped and held, deciding whether it is the packet's last
// OFFER     | held byte presented on pkt_*, waiting for pkt_ready
// FULL_WAIT | full packet just sent; a new byte continues, idle timeout sends a ZLP
// ZLP       | zero-length packet beat presented, waiting for pkt_ready
module usb_in_packetizer #(
  parameter int MAX_PACKET = 64,
  parameter int TIMEOUT    = 1024,
  parameter bit ZLP_EN     = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fifo_data_available,
  input  logic [7:0] fifo_read_data,
  output logic       fifo_read_strobe,
  output logic [7:0] pkt_data,
  output logic       pkt_valid,
  output logic       pkt_last,
  output logic       pkt_zlp,
  input  logic       pkt_ready
);

  localparam int CW = $clog2(MAX_PACKET);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_PACKET - 1);
  localparam logic [TW-1:0] TMR_MAX = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HOLD      = 3'd1,
    OFFER     = 3'd2,
    FULL_WAIT = 3'd3,
    ZLP       = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] byte_cnt;
  logic [TW-1:0] timer;
  logic [7:0]    hold;
  logic          pkt_full;
  logic          cnt_at_max;

  assign cnt_at_max = (byte_cnt == CNT_MAX);

  // A non-last beat is only ever offered when the fifo was non-empty, so the
  // pop on its acceptance always finds a byte.
  always_comb begin
    fifo_read_strobe = 1'b0;
    if (!reset) begin
      case (state)
        IDLE, FULL_WAIT: fifo_read_strobe = fifo_data_available;
        OFFER:           fifo_read_strobe = pkt_ready && !pkt_last;
        default:         fifo_read_strobe = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pkt_valid <= 1'b0;
      pkt_last  <= 1'b0;
      pkt_zlp   <= 1'b0;
      pkt_data  <= 8'h00;
      byte_cnt  <= '0;
      timer     <= '0;
      hold      <= 8'h00;
      pkt_full  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_data_available) begin
            hold  <= fifo_read_data;
            timer <= '0;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (cnt_at_max || fifo_data_available || timer == TMR_MAX) begin
            pkt_valid <= 1'b1;
            pkt_data  <= hold;
            pkt_last  <= cnt_at_max || !fifo_data_available;
            pkt_full  <= cnt_at_max;
            state     <= OFFER;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        OFFER: begin
          if (pkt_ready) begin
            pkt_valid <= 1'b0;
            pkt_last  <= 1'b0;
            timer     <= '0;
            if (!pkt_last) begin
              byte_cnt <= byte_cnt + 1'b1;
              hold     <= fifo_read_data;
              state    <= HOLD;
            end else begin
              byte_cnt <= '0;
              state    <= (pkt_full && ZLP_EN) ? FULL_WAIT : IDLE;
            end
          end
        end
        FULL_WAIT: begin
          if (fifo_data_available) begin
            hold  <= fifo_read_data;
            timer <= '0;
            state <= HOLD;
          end else if (timer == TMR_MAX) begin
            pkt_valid <= 1'b1;
            pkt_last  <= 1'b1;
            pkt_zlp   <= 1'b1;
            state     <= ZLP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ZLP: begin
          if (pkt_ready) begin
            pkt_valid <= 1'b0;
            pkt_last  <= 1'b0;
            pkt_zlp   <= 1'b0;
            timer     <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
